buffer_reader: RTL and testbench

BUFFER_READER -- requirements
Module: buffer_reader

---
 rtl/mic_pkg.sv | 6 +
 rtl/stream_skid_fifo.sv | 36 +++
 rtl/buffer_reader.sv | 109 ++++++++++
 tb/tb_buffer_reader.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/mic_pkg.sv
// mic_pkg: shared sample format and buffer-reader state encoding.
package mic_pkg;
    localparam int DATA_WIDTH      = 16;
    localparam int SAMPLES_PER_BUF = 256;
    typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_DRAIN} reader_state_t;
endpackage

// File: rtl/stream_skid_fifo.sv
// stream_skid_fifo: 2-entry registered FIFO; the head entry is stable while out_valid is held.
module stream_skid_fifo #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       count
);
    logic [WIDTH-1:0] mem [2];
    logic rp, wp, push, pop;
    assign push      = in_valid && count != 2'd2;
    assign pop       = out_valid && out_ready;
    assign out_valid = count != 2'd0;
    assign out_data  = mem[rp];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem[0] <= '0;
            mem[1] <= '0;
            rp     <= 1'b0;
            wp     <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wp] <= in_data;
                wp      <= ~wp;
            end
            if (pop) rp <= ~rp;
            count <= count + 2'(push) - 2'(pop);
        end
    end
endmodule

// File: rtl/buffer_reader.sv
// buffer_reader: streams each completed half-buffer out of the double-buffer RAM,
// with one pending request slot and credit-based reads into a 2-entry output FIFO.
module buffer_reader import mic_pkg::*; #(
    parameter int N_MICS          = 1,
    parameter int DATA_WIDTH      = mic_pkg::DATA_WIDTH,
    parameter int SAMPLES_PER_BUF = mic_pkg::SAMPLES_PER_BUF,
    parameter int ADDR_WIDTH      = $clog2(SAMPLES_PER_BUF),
    parameter int CH_W            = $clog2(N_MICS > 1 ? N_MICS : 2)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  buf_ready_pulse_i,
    input  logic [CH_W-1:0]       buf_ready_ch_i,
    input  logic                  active_buf_i,
    output logic                  rd_en_o,
    output logic [ADDR_WIDTH-1:0] rd_addr_o,
    output logic [CH_W-1:0]       rd_ch_o,
    output logic                  rd_buf_o,
    input  logic [DATA_WIDTH-1:0] rd_data_i,
    input  logic                  rd_data_valid_i,
    output logic [DATA_WIDTH-1:0] out_data_o,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic                  out_last_o,
    output logic [CH_W-1:0]       out_ch_o,
    output logic                  done_pulse_o,
    output logic                  busy_o,
    output logic                  overrun_o
);
    localparam int REC_W = DATA_WIDTH + 1 + CH_W;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(SAMPLES_PER_BUF - 1);
    reader_state_t state, state_nxt;
    logic [ADDR_WIDTH-1:0] addr;
    logic [CH_W-1:0] ch, pend_ch;
    logic buf_sel, pend_buf, pend_valid, overrun;
    logic [1:0] inflight, count;
    logic ret, pop, empty, drain_done, direct, use_pend, start, store, drop;
    logic [REC_W-1:0] head;
    assign ret        = rd_data_valid_i && inflight != 2'd0;
    assign pop        = out_valid_o && out_ready_i;
    assign empty      = count == 2'd0 && inflight == 2'd0;
    assign drain_done = state == ST_DRAIN && empty;
    assign direct     = buf_ready_pulse_i && (state == ST_IDLE || (drain_done && !pend_valid));
    assign use_pend   = drain_done && pend_valid;
    assign start      = direct || use_pend;
    assign store      = buf_ready_pulse_i && !direct && (!pend_valid || use_pend);
    assign drop       = buf_ready_pulse_i && !direct && pend_valid && !use_pend;
    // A beat leaving this cycle frees its slot, which keeps reads back-to-back at full rate.
    assign rd_en_o    = state == ST_READ && ({1'b0, count} - 3'(pop) + {1'b0, inflight}) < 3'd2;
    assign rd_addr_o  = addr;
    assign rd_ch_o    = ch;
    assign rd_buf_o   = buf_sel;
    assign busy_o     = state != ST_IDLE;
    assign overrun_o  = overrun;
    assign {out_data_o, out_last_o, out_ch_o} = head;
    assign done_pulse_o = pop && out_last_o;
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:  state_nxt = buf_ready_pulse_i ? ST_READ : ST_IDLE;
            ST_READ:  state_nxt = (rd_en_o && addr == LAST_ADDR) ? ST_DRAIN : ST_READ;
            ST_DRAIN: state_nxt = !empty ? ST_DRAIN : (pend_valid || buf_ready_pulse_i) ? ST_READ : ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state      <= ST_IDLE;
            addr       <= '0;
            ch         <= '0;
            buf_sel    <= 1'b0;
            pend_valid <= 1'b0;
            pend_ch    <= '0;
            pend_buf   <= 1'b0;
            overrun    <= 1'b0;
            inflight   <= 2'd0;
        end else begin
            state    <= state_nxt;
            inflight <= inflight + 2'(rd_en_o) - 2'(ret);
            overrun  <= overrun | drop;
            if (start) begin
                addr    <= '0;
                ch      <= use_pend ? pend_ch : buf_ready_ch_i;
                buf_sel <= use_pend ? pend_buf : ~active_buf_i;
            end else if (rd_en_o && addr != LAST_ADDR) begin
                addr <= addr + ADDR_WIDTH'(1);
            end
            if (store) begin
                pend_valid <= 1'b1;
                pend_ch    <= buf_ready_ch_i;
                pend_buf   <= ~active_buf_i;
            end else if (use_pend) begin
                pend_valid <= 1'b0;
            end
        end
    end
    // Reads return in order and none are issued after the final one, so in DRAIN
    // the return that empties the in-flight count is the last sample.
    stream_skid_fifo #(.WIDTH(REC_W)) u_fifo (
        .clk       (clk_i),
        .rst_n     (rst_ni),
        .in_valid  (ret),
        .in_data   ({rd_data_i, state == ST_DRAIN && inflight == 2'd1, ch}),
        .out_valid (out_valid_o),
        .out_ready (out_ready_i),
        .out_data  (head),
        .count     (count)
    );
endmodule

// File: tb/tb_buffer_reader.sv
// tb_buffer_reader: directed vectors plus stream scoreboard against a 1-cycle-latency RAM model.
module tb_buffer_reader;
    logic        clk = 1'b0, rst_n = 1'b0, pulse = 1'b0, active = 1'b0, out_ready = 1'b1;
    logic [0:0]  pulse_ch = 1'b0;
    logic        rd_en, rd_buf, out_valid, out_last, done, busy, overrun;
    logic [7:0]  rd_addr;
    logic [0:0]  rd_ch, out_ch;
    logic [15:0] rd_data = 16'h0, out_data;
    logic        rd_data_valid = 1'b0;
    int checks = 0, errors = 0;
    int cyc = 0, pulse_cyc = 0, done_cnt = 0, rd_cnt = 0, hold_viol = 0;
    logic [16:0] obs[$];
    int obs_cyc[$];
    logic prev_stall = 1'b0;
    logic [17:0] prev_beat = '0;
    logic rnd = 1'b0;

    typedef struct {
        logic        pulse, active, ready, exp_rd_en;
        logic [7:0]  exp_addr;
        logic        exp_valid;
        logic [15:0] exp_data;
        logic        exp_busy;
    } vec_t;
    vec_t vecs[10];

    buffer_reader dut (
        .clk_i (clk), .rst_ni (rst_n),
        .buf_ready_pulse_i (pulse), .buf_ready_ch_i (pulse_ch), .active_buf_i (active),
        .rd_en_o (rd_en), .rd_addr_o (rd_addr), .rd_ch_o (rd_ch), .rd_buf_o (rd_buf),
        .rd_data_i (rd_data), .rd_data_valid_i (rd_data_valid),
        .out_data_o (out_data), .out_valid_o (out_valid), .out_ready_i (out_ready),
        .out_last_o (out_last), .out_ch_o (out_ch), .done_pulse_o (done),
        .busy_o (busy), .overrun_o (overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        rd_data_valid <= rd_en;
        rd_data       <= (rd_buf ? 16'h6000 : 16'h5000) + 16'(rd_addr);
    end

    // Observes the cycle after inputs settle, ahead of the rising edge that acts on it.
    always begin
        @(negedge clk);
        #3;
        cyc++;
        if (rst_n) begin
            if (pulse) pulse_cyc = cyc;
            if (rd_en) rd_cnt++;
            if (done) done_cnt++;
            if (prev_stall && (!out_valid || {out_data, out_last, out_ch} != prev_beat)) hold_viol++;
            prev_stall = out_valid && !out_ready;
            prev_beat  = {out_data, out_last, out_ch};
            if (out_valid && out_ready) begin
                obs.push_back({out_data, out_last});
                obs_cyc.push_back(cyc);
            end
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        if (rnd) out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic send_pulse(input logic act);
        pulse  = 1'b1;
        active = act;
        tick();
        pulse  = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (busy && n < budget) begin
            tick();
            n++;
        end
        check("idle_timeout", 32'(busy), 32'd0);
    endtask

    task automatic wait_beats(input int target, input int budget);
        int n = 0;
        while (obs.size() < target && n < budget) begin
            tick();
            n++;
        end
        check("beat_timeout", 32'(obs.size() >= target), 32'd1);
    endtask

    task automatic check_stream(input int s, input int nb, input logic [15:0] b0, input logic [15:0] b1);
        logic [16:0] exp;
        check("beat_count", 32'(obs.size() - s), 32'(nb * 256));
        for (int i = 0; i < nb * 256 && s + i < obs.size(); i++) begin
            exp = {(i < 256 ? b0 : b1) + 16'(i % 256), i % 256 == 255};
            check($sformatf("beat%0d", i), 32'(obs[s + i]), 32'(exp));
        end
    endtask

    task automatic check_reset_zero();
        check("rst_rd", 32'({rd_en, rd_addr, rd_ch, rd_buf}), 32'd0);
        check("rst_out", 32'({out_data, out_valid, out_last, out_ch, done}), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
    endtask

    initial begin
        int s, d, r;
        vecs[0] = '{1'b1, 1'b1, 1'b1, 1'b0, 8'd0, 1'b0, 16'h0000, 1'b0};
        vecs[1] = '{1'b0, 1'b1, 1'b1, 1'b1, 8'd0, 1'b0, 16'h0000, 1'b1};
        vecs[2] = '{1'b0, 1'b1, 1'b1, 1'b1, 8'd1, 1'b0, 16'h0000, 1'b1};
        vecs[3] = '{1'b0, 1'b1, 1'b1, 1'b1, 8'd2, 1'b1, 16'h5000, 1'b1};
        vecs[4] = '{1'b0, 1'b1, 1'b1, 1'b1, 8'd3, 1'b1, 16'h5001, 1'b1};
        vecs[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'd4, 1'b1, 16'h5002, 1'b1};
        vecs[6] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'd4, 1'b1, 16'h5002, 1'b1};
        vecs[7] = '{1'b0, 1'b1, 1'b1, 1'b1, 8'd4, 1'b1, 16'h5002, 1'b1};
        vecs[8] = '{1'b0, 1'b1, 1'b1, 1'b1, 8'd5, 1'b1, 16'h5003, 1'b1};
        vecs[9] = '{1'b0, 1'b1, 1'b1, 1'b1, 8'd6, 1'b1, 16'h5004, 1'b1};

        #1;
        check_reset_zero();
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Cycle-exact start-up and backpressure window, then finish that buffer.
        s = obs.size();
        for (int i = 0; i < 10; i++) begin
            pulse     = vecs[i].pulse;
            active    = vecs[i].active;
            out_ready = vecs[i].ready;
            #1;
            check($sformatf("vec%0d_rd_en", i), 32'(rd_en), 32'(vecs[i].exp_rd_en));
            check($sformatf("vec%0d_addr", i), 32'(rd_addr), 32'(vecs[i].exp_addr));
            check($sformatf("vec%0d_valid", i), 32'(out_valid), 32'(vecs[i].exp_valid));
            if (vecs[i].exp_valid) check($sformatf("vec%0d_data", i), 32'(out_data), 32'(vecs[i].exp_data));
            check($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].exp_busy));
            tick();
        end
        pulse = 1'b0;
        out_ready = 1'b1;
        wait_idle(1000);
        check_stream(s, 1, 16'h5000, 16'h5000);

        // Full-rate stream from buffer A.
        s = obs.size();
        d = done_cnt;
        send_pulse(1'b1);
        check("rd_buf_a", 32'(rd_buf), 32'd0);
        wait_idle(1000);
        check_stream(s, 1, 16'h5000, 16'h5000);
        check("done_once", 32'(done_cnt - d), 32'd1);
        if (obs.size() >= s + 256) begin
            check("consecutive", 32'(obs_cyc[s + 255] - obs_cyc[s]), 32'd255);
            check("first_latency_le3", 32'(obs_cyc[s] - pulse_cyc <= 3), 32'd1);
        end

        // Random backpressure.
        s = obs.size();
        d = done_cnt;
        r = rd_cnt;
        rnd = 1'b1;
        send_pulse(1'b1);
        wait_idle(3000);
        rnd = 1'b0;
        out_ready = 1'b1;
        check_stream(s, 1, 16'h5000, 16'h5000);
        check("rd_en_count", 32'(rd_cnt - r), 32'd256);
        check("done_once_rnd", 32'(done_cnt - d), 32'd1);
        check("hold_stable", 32'(hold_viol), 32'd0);

        // Second request queued while streaming.
        s = obs.size();
        send_pulse(1'b1);
        wait_beats(s + 10, 100);
        send_pulse(1'b0);
        wait_idle(2000);
        check_stream(s, 2, 16'h5000, 16'h6000);
        check("no_overrun", 32'(overrun), 32'd0);

        // Three pulses back to back: the third has nowhere to go.
        s = obs.size();
        d = done_cnt;
        send_pulse(1'b1);
        send_pulse(1'b0);
        send_pulse(1'b1);
        check("overrun_set", 32'(overrun), 32'd1);
        wait_idle(2000);
        check_stream(s, 2, 16'h5000, 16'h6000);
        check("done_twice", 32'(done_cnt - d), 32'd2);
        check("overrun_sticky", 32'(overrun), 32'd1);

        // Reset in the middle of a stream.
        s = obs.size();
        send_pulse(1'b1);
        wait_beats(s + 100, 200);
        rst_n = 1'b0;
        #1;
        check_reset_zero();
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        s = obs.size();
        send_pulse(1'b1);
        wait_idle(1000);
        check_stream(s, 1, 16'h5000, 16'h5000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
